// File: rtl/uart_rx_if.sv
// Serial-in / byte-out signal bundle for the UART receiver.
// The master side drives the line and consumes received bytes; the slave side is the receiver.
interface uart_rx_if;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_RX_Frame_Err;

  modport master (
    output i_RX_Serial,
    input  o_RX_DV,
    input  o_RX_Byte,
    input  o_RX_Active,
    input  o_RX_Frame_Err
  );

  modport slave (
    input  i_RX_Serial,
    output o_RX_DV,
    output o_RX_Byte,
    output o_RX_Active,
    output o_RX_Frame_Err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled bits, glitch-rejecting start detection,
// one-cycle valid / framing-error pulses, all outputs registered.
module uart_rx #(
  parameter int BIT_PERIOD = 217
) (
  input  logic     i_Clk,
  input  logic     i_Rst,
  uart_rx_if.slave rx
);

  localparam int            CW   = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0] HALF = CW'((BIT_PERIOD - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t        state_r, state_nxt;
  logic [1:0]    r_rx_sync;
  logic          rx_s;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic [2:0]    idx_r, idx_nxt;
  logic [7:0]    shift_r, shift_nxt;
  logic          dv_r, dv_nxt;
  logic          err_r, err_nxt;
  logic          active_r, active_nxt;
  logic [7:0]    byte_r, byte_nxt;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_rx_sync <= 2'b11;
    end else begin
      r_rx_sync <= {r_rx_sync[0], rx.i_RX_Serial};
    end
  end

  assign rx_s = r_rx_sync[1];

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and bit-timing datapath.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    idx_nxt   = idx_r;
    shift_nxt = shift_r;
    case (state_r)
      IDLE: begin
        cnt_nxt = {CW{1'b0}};
        idx_nxt = 3'd0;
        if (!rx_s) begin
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF) begin
          cnt_nxt   = {CW{1'b0}};
          // Line back high at mid-start means it was a glitch.
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DATA: begin
        if (cnt_r == LAST) begin
          cnt_nxt          = {CW{1'b0}};
          shift_nxt[idx_r] = rx_s;
          if (idx_r == 3'd7) begin
            idx_nxt   = 3'd0;
            state_nxt = STOP;
          end else begin
            idx_nxt = idx_r + 3'd1;
          end
        end else begin
          cnt_nxt = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      STOP: begin
        if (cnt_r == LAST) begin
          cnt_nxt   = {CW{1'b0}};
          state_nxt = CLEANUP;
        end else begin
          cnt_nxt = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      CLEANUP: begin
        cnt_nxt   = {CW{1'b0}};
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = {CW{1'b0}};
        idx_nxt   = 3'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: pulses come from the stop-bit sample, active follows the next state.
  always_comb begin
    dv_nxt     = 1'b0;
    err_nxt    = 1'b0;
    byte_nxt   = byte_r;
    active_nxt = (state_nxt == START) || (state_nxt == DATA) || (state_nxt == STOP);
    if ((state_r == STOP) && (cnt_r == LAST)) begin
      if (rx_s) begin
        dv_nxt   = 1'b1;
        byte_nxt = shift_r;
      end else begin
        err_nxt = 1'b1;
      end
    end else begin
      dv_nxt  = 1'b0;
      err_nxt = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_r    <= {CW{1'b0}};
      idx_r    <= 3'd0;
      shift_r  <= 8'h00;
      dv_r     <= 1'b0;
      err_r    <= 1'b0;
      active_r <= 1'b0;
      byte_r   <= 8'h00;
    end else begin
      cnt_r    <= cnt_nxt;
      idx_r    <= idx_nxt;
      shift_r  <= shift_nxt;
      dv_r     <= dv_nxt;
      err_r    <= err_nxt;
      active_r <= active_nxt;
      byte_r   <= byte_nxt;
    end
  end

  assign rx.o_RX_DV        = dv_r;
  assign rx.o_RX_Byte      = byte_r;
  assign rx.o_RX_Active    = active_r;
  assign rx.o_RX_Frame_Err = err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed vector table, hand-written corner
// sequences and random frames checked against a frame-level event model.
module tb_uart_rx;

  localparam int BP   = 217;
  localparam int HALF = (BP - 1) / 2;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
    bit         glitch;
    bit         exp_err;
    logic [7:0] exp_byte;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   last_dv_cyc;
  bit   prev_dv;
  bit   prev_err;
  ev_t  obs_q[$];

  uart_rx_if u_if ();

  uart_rx #(.BIT_PERIOD(BP)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .rx    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: records every pulse as an event and checks pulse shape.
  always @(negedge clk) begin
    if (u_if.o_RX_DV === 1'b1) begin
      check("dv_single_cycle", {31'd0, prev_dv}, 32'd0);
      check("dv_err_exclusive", {31'd0, u_if.o_RX_Frame_Err}, 32'd0);
      obs_q.push_back('{1'b0, u_if.o_RX_Byte});
      last_dv_cyc = cyc;
    end
    if (u_if.o_RX_Frame_Err === 1'b1) begin
      check("err_single_cycle", {31'd0, prev_err}, 32'd0);
      obs_q.push_back('{1'b1, u_if.o_RX_Byte});
    end
    prev_dv  = (u_if.o_RX_DV === 1'b1);
    prev_err = (u_if.o_RX_Frame_Err === 1'b1);
  end

  task automatic idle(input int n);
    u_if.i_RX_Serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop);
    u_if.i_RX_Serial = 1'b0;
    repeat (4) @(negedge clk);
    check("active_at_start", {31'd0, u_if.o_RX_Active}, 32'd1);
    repeat (BP - 4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_if.i_RX_Serial = d[i];
      repeat (BP) @(negedge clk);
    end
    u_if.i_RX_Serial = stop;
    repeat (BP) @(negedge clk);
    u_if.i_RX_Serial = 1'b1;
  endtask

  task automatic expect_event(input string name, input bit exp_err, input logic [7:0] exp_byte);
    ev_t e;
    if (obs_q.size() == 0) begin
      check({name, "_present"}, 32'd0, 32'd1);
    end else begin
      e = obs_q.pop_front();
      check({name, "_kind"}, {31'd0, e.err}, {31'd0, exp_err});
      check({name, "_byte"}, {24'd0, e.data}, {24'd0, exp_byte});
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_dv"}, {31'd0, u_if.o_RX_DV}, 32'd0);
    check({name, "_err"}, {31'd0, u_if.o_RX_Frame_Err}, 32'd0);
    check({name, "_active"}, {31'd0, u_if.o_RX_Active}, 32'd0);
    check({name, "_byte"}, {24'd0, u_if.o_RX_Byte}, 32'd0);
  endtask

  initial begin
    vec_t       vecs[7];
    logic [7:0] ref_byte;
    logic [7:0] d;
    logic [7:0] c3;
    bit         stop;
    bit         prev_bad;
    int         gap;
    int         lat;
    int         exp_lat;
    int         n_err;
    int         n_dv;

    checks = 0;
    errors = 0;
    cyc = 0;
    last_dv_cyc = 0;
    prev_dv = 1'b0;
    prev_err = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 20,     1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,      1'b0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,      1'b0, 1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b1, 0,      1'b0, 1'b0, 8'h3C};
    vecs[4] = '{8'h5A, 1'b1, 40,     1'b1, 1'b0, 8'h5A};
    vecs[5] = '{8'h81, 1'b0, 20,     1'b0, 1'b1, 8'h5A};
    vecs[6] = '{8'h7E, 1'b1, 2 * BP, 1'b0, 1'b0, 8'h7E};

    u_if.i_RX_Serial = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    ref_byte = 8'h00;

    for (int v = 0; v < 7; v++) begin
      idle(vecs[v].gap);
      if (vecs[v].glitch) begin
        u_if.i_RX_Serial = 1'b0;
        repeat (50) @(negedge clk);
        idle(2 * BP);
        check("glitch_no_event", obs_q.size(), 32'd0);
        check("glitch_idle", {31'd0, u_if.o_RX_Active}, 32'd0);
      end
      send_frame(vecs[v].data, vecs[v].stop);
      expect_event($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_byte);
      check($sformatf("vec%0d_hold", v), {24'd0, u_if.o_RX_Byte}, {24'd0, vecs[v].exp_byte});
      ref_byte = vecs[v].exp_byte;
    end

    // Random frames against the frame-level model.
    prev_bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      gap  = prev_bad ? (2 * BP + int'($urandom_range(0, 50))) : int'($urandom_range(0, 30));
      idle(gap);
      send_frame(d, stop);
      if (stop) begin
        ref_byte = d;
      end
      expect_event($sformatf("rand%0d", k), !stop, ref_byte);
      check($sformatf("rand%0d_hold", k), {24'd0, u_if.o_RX_Byte}, {24'd0, ref_byte});
      prev_bad = !stop;
    end

    // Start-edge to valid latency for 8'h55.
    idle(2 * BP);
    lat = cyc;
    send_frame(8'h55, 1'b1);
    expect_event("lat55", 1'b0, 8'h55);
    ref_byte = 8'h55;
    lat = last_dv_cyc - lat - 3;
    exp_lat = 1 + HALF + 1 + 9 * BP + 1;
    check($sformatf("latency_%0d_vs_%0d", lat, exp_lat),
          {31'd0, (lat >= exp_lat - 2) && (lat <= exp_lat + 2)}, 32'd1);

    // Reset during data bit 4 of 8'hC3, then a clean 8'h96.
    idle(20);
    c3 = 8'hC3;
    u_if.i_RX_Serial = 1'b0;
    repeat (BP) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      u_if.i_RX_Serial = c3[i];
      repeat (BP) @(negedge clk);
    end
    u_if.i_RX_Serial = c3[4];
    repeat (BP / 2) @(negedge clk);
    rst = 1'b1;
    u_if.i_RX_Serial = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    ref_byte = 8'h00;
    idle(3 * BP);
    check("midrst_no_event", obs_q.size(), 32'd0);
    send_frame(8'h96, 1'b1);
    expect_event("after_rst", 1'b0, 8'h96);
    ref_byte = 8'h96;

    // Break: line held low for 30 bit times gives a frame error roughly every 10 bits.
    idle(20);
    u_if.i_RX_Serial = 1'b0;
    repeat (30 * BP) @(negedge clk);
    n_err = 0;
    n_dv = 0;
    while (obs_q.size() > 0) begin
      ev_t e;
      e = obs_q.pop_front();
      if (e.err) begin
        n_err++;
      end else begin
        n_dv++;
      end
      check("break_byte_kept", {24'd0, e.data}, {24'd0, ref_byte});
    end
    check("break_err_count", n_err, 32'd3);
    check("break_dv_count", n_dv, 32'd0);
    rst = 1'b1;
    u_if.i_RX_Serial = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("final_rst");
    idle(2 * BP);
    check("no_spurious_events", obs_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
